// File: rtl/monitor_sym_pkg.sv
// Shared types and constants for the runtime-monitor symbol encoder.
// SEP is always declared; it is only reachable when MON_SEP_EN is defined.
package monitor_sym_pkg;

  typedef logic [7:0] symbol_t;

  localparam symbol_t SYM_BASE_DEF = 8'h01;
  localparam symbol_t SYM_NULL_DEF = 8'h00;
  localparam symbol_t SYM_SEP_DEF  = 8'hFF;

  // Widest event vector the index helper can scan.
  localparam int MAX_EVT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    SEP  = 2'd2
  } enc_state_e;

  function automatic symbol_t lsb_index(input logic [MAX_EVT-1:0] v);
    lsb_index = '0;
    for (int i = MAX_EVT - 1; i >= 0; i--) begin
      if (v[i]) lsb_index = symbol_t'(i);
    end
  endfunction

endpackage

// File: rtl/monitor_evt_fifo.sv
// Event-vector FIFO: power-of-2 depth, registered full/empty, synchronous clear.
// A push while full is dropped even if a pop happens in the same cycle.
module monitor_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("monitor_evt_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         full_q, empty_q;
  logic         do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;
  assign wr_d    = wr_q + (AW+1)'(do_push);
  assign rd_d    = rd_q + (AW+1)'(do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      // Pointers carry one wrap bit: equal index with differing wrap bit means full.
      full_q  <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
      empty_q <= (wr_d == rd_d);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/monitor_symbol_encoder.sv
// Serializes buffered multi-hot event vectors into one 8-bit monitor symbol per cycle.
// Define MON_SEP_EN to append SYM_SEP after every nonzero vector.
module monitor_symbol_encoder
  import monitor_sym_pkg::*;
#(
  parameter int      NUM_EVT  = 8,
  parameter int      DEPTH    = 4,
  parameter symbol_t SYM_BASE = SYM_BASE_DEF,
  parameter symbol_t SYM_NULL = SYM_NULL_DEF,
  parameter symbol_t SYM_SEP  = SYM_SEP_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic [NUM_EVT-1:0] evt_bits,
  input  logic               flush,
  output symbol_t            symbols,
  output logic               run,
  output logic               mon_reset,
  output logic [15:0]        sym_count,
  output enc_state_e         dbg_state
);

  localparam int EVT_LAST = int'(SYM_BASE) + NUM_EVT - 1;

  if (NUM_EVT < 1 || NUM_EVT > MAX_EVT) begin : g_chk_width
    $error("monitor_symbol_encoder: NUM_EVT out of range");
  end
  if (EVT_LAST > 'hFE) begin : g_chk_base
    $error("monitor_symbol_encoder: event symbols overflow 8'hFE");
  end
  if (int'(SYM_NULL) >= int'(SYM_BASE) && int'(SYM_NULL) <= EVT_LAST) begin : g_chk_null
    $error("monitor_symbol_encoder: SYM_NULL collides with event range");
  end
  if (int'(SYM_SEP) >= int'(SYM_BASE) && int'(SYM_SEP) <= EVT_LAST) begin : g_chk_sep
    $error("monitor_symbol_encoder: SYM_SEP collides with event range");
  end

`ifdef MON_SEP_EN
  localparam enc_state_e AFTER_LAST = SEP;
`else
  localparam enc_state_e AFTER_LAST = IDLE;
`endif

  // Handshake: a vector transfers on a rising clk edge where evt_valid && evt_ready;
  // evt_ready depends only on registered FIFO state and flush, never on evt_valid.
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [NUM_EVT-1:0] fifo_rdata;

  assign evt_ready = !fifo_full && !flush;
  assign fifo_push = evt_valid && evt_ready;

  monitor_evt_fifo #(
    .W     (NUM_EVT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (evt_bits),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  enc_state_e         state_q, state_d;
  logic [NUM_EVT-1:0] cur_q, cur_d;
  logic [NUM_EVT-1:0] src_vec, src_rest;
  symbol_t            symbols_q, symbols_d, evt_sym;
  logic               run_q, run_d;
  logic               mon_reset_q;
  logic [15:0]        sym_count_q;

  // The first symbol of a vector goes out on the pop itself, so cur holds only what is left.
  assign src_vec  = (state_q == IDLE) ? fifo_rdata : cur_q;
  assign src_rest = src_vec & (src_vec - NUM_EVT'(1));
  assign evt_sym  = SYM_BASE + lsb_index(MAX_EVT'(src_vec));

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    symbols_d = symbols_q;
    run_d     = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          run_d    = 1'b1;
          if (fifo_rdata == '0) begin
            symbols_d = SYM_NULL;
          end else begin
            symbols_d = evt_sym;
            cur_d     = src_rest;
            state_d   = (src_rest == '0) ? AFTER_LAST : EMIT;
          end
        end
      end
      EMIT: begin
        run_d     = 1'b1;
        symbols_d = evt_sym;
        cur_d     = src_rest;
        if (src_rest == '0) state_d = AFTER_LAST;
      end
`ifdef MON_SEP_EN
      SEP: begin
        run_d     = 1'b1;
        symbols_d = SYM_SEP;
        state_d   = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      symbols_q   <= '0;
      run_q       <= 1'b0;
      mon_reset_q <= 1'b1;
      sym_count_q <= '0;
    end else if (flush) begin
      // Symbols keep their last value; everything in flight is dropped.
      state_q     <= IDLE;
      cur_q       <= '0;
      run_q       <= 1'b0;
      mon_reset_q <= 1'b1;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      symbols_q   <= symbols_d;
      run_q       <= run_d;
      mon_reset_q <= 1'b0;
      sym_count_q <= sym_count_q + 16'(run_d);
    end
  end

  assign symbols   = symbols_q;
  assign run       = run_q;
  assign mon_reset = mon_reset_q;
  assign sym_count = sym_count_q;
  assign dbg_state = state_q;

endmodule
